// File: rtl/aq_f_spsram_pkg.sv
// ---------------------------------------------------------------------------
// aq_f_spsram_pkg
// Shared constants and types for the single-port SRAM request controller.
//   ADDR_WIDTH_DFLT / DATA_WIDTH_DFLT : default macro geometry (1024 x 16)
//   RSP_DEPTH                        : read response buffer depth
//   RSP_OCC_W                        : width of a response occupancy count
//   state_e                          : controller FSM encoding
//   rsp_has_room()                   : space test covering buffered and
//                                      in-flight responses together
// ---------------------------------------------------------------------------
package aq_f_spsram_pkg;

  localparam int ADDR_WIDTH_DFLT = 10;
  localparam int DATA_WIDTH_DFLT = 16;
  localparam int RSP_DEPTH       = 2;
  localparam int RSP_OCC_W       = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A read already issued to the macro owns a buffer slot even though its
  // data has not arrived yet, so it is counted alongside the stored entries.
  function automatic logic rsp_has_room(input logic [RSP_OCC_W-1:0] occ,
                                        input logic                 rd_inflight);
    logic [RSP_OCC_W:0] used;
    used = {1'b0, occ} + {{RSP_OCC_W{1'b0}}, rd_inflight};
    return used < (RSP_OCC_W+1)'(RSP_DEPTH);
  endfunction

endpackage

// File: rtl/aq_f_spsram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// aq_f_spsram_rsp_fifo
// Two-entry in-order FIFO holding read responses that the consumer has not
// yet taken. Simultaneous push and pop is allowed at any occupancy,
// including full, and keeps ordering.
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   push        write push_data at the tail (ignored when full without pop)
//   push_data   DATA_WIDTH entry to store
//   pop         remove the head entry (ignored when empty)
//   head_data   oldest stored entry
//   occ         number of stored entries, 0..RSP_DEPTH
//   empty       occ == 0
// ---------------------------------------------------------------------------
module aq_f_spsram_rsp_fifo
  import aq_f_spsram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [RSP_OCC_W-1:0]  occ,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [RSP_OCC_W-1:0]  occ_q, occ_d;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;

  always_comb begin
    full    = (occ_q == RSP_OCC_W'(RSP_DEPTH));
    empty   = (occ_q == '0);
    pop_ok  = pop & ~empty;
    // When full, the slot being written is the one being popped this cycle,
    // so a push is only safe together with a pop.
    push_ok = push & (~full | pop_ok);

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    occ_d    = occ_q + RSP_OCC_W'(push_ok) - RSP_OCC_W'(pop_ok);

    head_data = mem_q[rd_ptr_q];
    occ       = occ_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/aq_f_spsram_req_ctrl.sv
// ---------------------------------------------------------------------------
// aq_f_spsram_req_ctrl
// Request-side controller for a single-port SRAM macro (1-cycle read
// latency, active-low CEN/GWEN/WEN). Turns a valid/ready read/write request
// stream into macro strobes and returns read data through a 2-entry response
// buffer with valid/ready backpressure.
//
// Build option: define AQ_F_SPSRAM_INIT_EN to zero-fill the whole array after
// reset (INIT state); undefined, the controller goes straight to RUN and
// init_done is tied high.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   req_vld/req_rdy          request handshake
//   req_wr                   1 = write, 0 = read
//   req_addr                 word address
//   req_wdata/req_wmask      write data, per-bit write enable (active-high)
//   rsp_vld/rsp_rdy          read response handshake
//   rsp_rdata                read data of the oldest outstanding response
//   init_done                array usable
//   sram_a/sram_d            macro address / write data (held when idle)
//   sram_cen/sram_gwen       macro chip / global write enable, active-low
//   sram_wen                 macro per-bit write enable, active-low
//   sram_q                   macro read data, valid the cycle after a read
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid must not depend on ready. req_rdy depends on req_wr
// (writes never wait for response space); rsp_vld does not depend on rsp_rdy.
// ---------------------------------------------------------------------------
module aq_f_spsram_req_ctrl
  import aq_f_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_e                state_q, state_d;
  // Low while reset is held and for the first edge after release, so the
  // macro sees no strobes and req_rdy stays low during reset.
  logic                  live_q, live_d;
  // Set the cycle after a read is accepted: sram_q carries its data then.
  logic                  rd_inflight_q, rd_inflight_d;
  logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
  logic [DATA_WIDTH-1:0] sram_d_q, sram_d_d;

  logic                  init_wr;
  logic                  init_last;
  logic [ADDR_WIDTH-1:0] init_addr;

  logic                  room;
  logic                  acc;
  logic                  acc_wr;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [RSP_OCC_W-1:0]  fifo_occ;

`ifdef AQ_F_SPSRAM_INIT_EN
  localparam state_e ST_RESET = ST_INIT;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // One zero write per cycle, sweeping the whole address range once.
  always_comb begin
    init_wr   = live_q & (state_q == ST_INIT);
    init_last = init_wr & (cnt_q == {ADDR_WIDTH{1'b1}});
    init_addr = cnt_q;
    cnt_d     = cnt_q;
    if (init_wr) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
    init_done = (state_q == ST_RUN);
  end
`else
  localparam state_e ST_RESET = ST_RUN;

  always_comb begin
    init_wr   = 1'b0;
    init_last = 1'b0;
    init_addr = '0;
    init_done = 1'b1;
  end
`endif

  // Request acceptance and macro strobes.
  always_comb begin
    room    = rsp_has_room(fifo_occ, rd_inflight_q);
    req_rdy = live_q & (state_q == ST_RUN) & (req_wr | room);
    acc     = req_vld & req_rdy;
    acc_wr  = acc & req_wr;

    sram_cen  = ~(acc | init_wr);
    sram_gwen = ~(acc_wr | init_wr);
    sram_wen  = init_wr ? '0 : ~(req_wmask & {DATA_WIDTH{acc_wr}});
    sram_a    = init_wr ? init_addr : (acc ? req_addr : sram_a_q);
    sram_d    = init_wr ? '0 : (acc ? req_wdata : sram_d_q);
  end

  // Next-state values.
  always_comb begin
    live_d        = 1'b1;
    rd_inflight_d = acc & ~req_wr;
    sram_a_d      = sram_a;
    sram_d_d      = sram_d;
    state_d       = state_q;
    if (init_last) begin
      state_d = ST_RUN;
    end
  end

  // Response path. The in-flight read is presented straight from sram_q when
  // nothing older is buffered; if it is not taken that cycle it is parked in
  // the FIFO behind any older entries.
  always_comb begin
    fifo_push = rd_inflight_q & ~(rsp_rdy & fifo_empty);
    fifo_pop  = rsp_rdy & ~fifo_empty;
    rsp_vld   = rd_inflight_q | ~fifo_empty;
    rsp_rdata = '0;
    if (!fifo_empty) begin
      rsp_rdata = fifo_head;
    end else if (rd_inflight_q) begin
      rsp_rdata = sram_q;
    end
  end

  aq_f_spsram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_data (sram_q),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .occ       (fifo_occ),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_RESET;
      live_q        <= 1'b0;
      rd_inflight_q <= 1'b0;
      sram_a_q      <= '0;
      sram_d_q      <= '0;
`ifdef AQ_F_SPSRAM_INIT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      live_q        <= live_d;
      rd_inflight_q <= rd_inflight_d;
      sram_a_q      <= sram_a_d;
      sram_d_q      <= sram_d_d;
`ifdef AQ_F_SPSRAM_INIT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule
